sys_ctrl_tx_ser: RTL and testbench

SYS_CTRL_TX_SER -- requirements
Module: SYS_CTRL_TX_SER

---
 rtl/sys_ctrl_tx_ser.sv | 143 ++++++++++++++
 tb/tb_sys_ctrl_tx_ser.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl_tx_ser.sv
// Serialises register-read and ALU-result events into DATA_WIDTH words for a FIFO.
// Latency: one cycle from strobe to first word. Backpressure: Full stalls FIFO_IN; one pending slot, extra strobes dropped.
module sys_ctrl_tx_ser #(
    parameter int DATA_WIDTH    = 8,
    parameter int ALU_OUT_WIDTH = 16,
    parameter int MSB_FIRST     = 0
) (
    input  logic                     CLK,
    input  logic                     rst_n,
    input  logic                     Full,
    input  logic [DATA_WIDTH-1:0]    Rd_data,
    input  logic                     Rd_data_valid,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     ALU_OUT_valid,
    output logic [DATA_WIDTH-1:0]    FIFO_IN,
    output logic                     Wr_Req,
    output logic                     Busy,
    output logic                     Drop
);
    localparam int ALU_WORDS = ALU_OUT_WIDTH / DATA_WIDTH;
    localparam int CW        = $clog2(ALU_WORDS + 1);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t                   r_state, w_nxt_state;
    logic [ALU_OUT_WIDTH-1:0] r_frame;
    logic [CW-1:0]            r_cnt, r_last, w_cnt_nxt;
    logic [DATA_WIDTH-1:0]    r_fifo_in;
    logic                     r_drop;
    logic                     r_pend_vld, r_pend_alu;
    logic [ALU_OUT_WIDTH-1:0] r_pend_dat;

    logic                     w_acc, w_last;
    logic                     w_start, w_start_alu;
    logic [ALU_OUT_WIDTH-1:0] w_start_dat, w_rd_ext;
    logic                     w_rd_left, w_alu_left, w_slot_free;
    logic                     w_pend_load, w_pend_alu, w_clr_pend, w_drop;
    logic [ALU_OUT_WIDTH-1:0] w_pend_dat;

    function automatic logic [DATA_WIDTH-1:0] word_sel(input logic [ALU_OUT_WIDTH-1:0] f,
                                                       input logic [CW-1:0] k);
        int idx;
        idx = (MSB_FIRST != 0) ? (ALU_WORDS - 1 - int'(k)) : int'(k);
        return f[idx*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    assign w_acc     = (r_state == SEND) && !Full;
    assign w_last    = w_acc && (r_cnt == r_last);
    assign w_cnt_nxt = r_cnt + 1'b1;

    always_comb begin
        w_rd_ext                   = '0;
        w_rd_ext[DATA_WIDTH-1:0]   = Rd_data;
    end

    // A frame may start when idle or on the edge that retires the last word;
    // the pending slot has priority, then read, then ALU. Leftovers try the slot.
    always_comb begin
        w_nxt_state = r_state;
        w_start     = 1'b0;
        w_start_alu = 1'b0;
        w_start_dat = '0;
        w_rd_left   = Rd_data_valid;
        w_alu_left  = ALU_OUT_valid;
        w_slot_free = !r_pend_vld;
        w_clr_pend  = 1'b0;
        w_pend_load = 1'b0;
        w_pend_alu  = 1'b0;
        w_pend_dat  = '0;
        w_drop      = 1'b0;
        if (r_state == IDLE || w_last) begin
            w_nxt_state = IDLE;
            if (r_pend_vld) begin
                w_start     = 1'b1;
                w_start_alu = r_pend_alu;
                w_start_dat = r_pend_dat;
                w_clr_pend  = 1'b1;
                w_slot_free = 1'b1;
            end else if (Rd_data_valid) begin
                w_start     = 1'b1;
                w_start_dat = w_rd_ext;
                w_rd_left   = 1'b0;
            end else if (ALU_OUT_valid) begin
                w_start     = 1'b1;
                w_start_alu = 1'b1;
                w_start_dat = ALU_OUT;
                w_alu_left  = 1'b0;
            end
        end
        if (w_start)
            w_nxt_state = SEND;
        if (w_slot_free) begin
            if (w_rd_left) begin
                w_pend_load = 1'b1;
                w_pend_dat  = w_rd_ext;
            end else if (w_alu_left) begin
                w_pend_load = 1'b1;
                w_pend_alu  = 1'b1;
                w_pend_dat  = ALU_OUT;
            end
        end
        w_drop = (w_rd_left && w_alu_left) || ((w_rd_left || w_alu_left) && !w_slot_free);
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_frame    <= '0;
            r_cnt      <= '0;
            r_last     <= '0;
            r_fifo_in  <= '0;
            r_drop     <= 1'b0;
            r_pend_vld <= 1'b0;
            r_pend_alu <= 1'b0;
            r_pend_dat <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_drop  <= w_drop;
            if (w_start) begin
                r_frame   <= w_start_dat;
                r_cnt     <= '0;
                r_last    <= w_start_alu ? CW'(ALU_WORDS - 1) : '0;
                r_fifo_in <= w_start_alu ? word_sel(w_start_dat, '0)
                                         : w_start_dat[DATA_WIDTH-1:0];
            end else if (w_acc && !w_last) begin
                r_cnt     <= w_cnt_nxt;
                r_fifo_in <= word_sel(r_frame, w_cnt_nxt);
            end
            if (w_pend_load) begin
                r_pend_vld <= 1'b1;
                r_pend_alu <= w_pend_alu;
                r_pend_dat <= w_pend_dat;
            end else if (w_clr_pend) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    assign FIFO_IN = r_fifo_in;
    assign Wr_Req  = (r_state == SEND);
    assign Busy    = (r_state == SEND) || r_pend_vld;
    assign Drop    = r_drop;
endmodule

// File: tb/tb_sys_ctrl_tx_ser.sv
// Directed bench for sys_ctrl_tx_ser: LSB-first, MSB-first and 32-bit ALU instances share stimulus.
module tb_sys_ctrl_tx_ser;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        full;
    logic [7:0]  rd_dat;
    logic        rd_vld;
    logic [31:0] alu_dat;
    logic        alu_vld;

    logic [7:0]  a_fifo, b_fifo, c_fifo;
    logic        a_wr, b_wr, c_wr;
    logic        a_busy, b_busy, c_busy;
    logic        a_drop, b_drop, c_drop;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sys_ctrl_tx_ser #(.DATA_WIDTH(8), .ALU_OUT_WIDTH(16), .MSB_FIRST(0)) u_lsb (
        .CLK(clk), .rst_n(rst_n), .Full(full), .Rd_data(rd_dat), .Rd_data_valid(rd_vld),
        .ALU_OUT(alu_dat[15:0]), .ALU_OUT_valid(alu_vld),
        .FIFO_IN(a_fifo), .Wr_Req(a_wr), .Busy(a_busy), .Drop(a_drop));

    sys_ctrl_tx_ser #(.DATA_WIDTH(8), .ALU_OUT_WIDTH(16), .MSB_FIRST(1)) u_msb (
        .CLK(clk), .rst_n(rst_n), .Full(full), .Rd_data(rd_dat), .Rd_data_valid(rd_vld),
        .ALU_OUT(alu_dat[15:0]), .ALU_OUT_valid(alu_vld),
        .FIFO_IN(b_fifo), .Wr_Req(b_wr), .Busy(b_busy), .Drop(b_drop));

    sys_ctrl_tx_ser #(.DATA_WIDTH(8), .ALU_OUT_WIDTH(32), .MSB_FIRST(0)) u_w32 (
        .CLK(clk), .rst_n(rst_n), .Full(full), .Rd_data(rd_dat), .Rd_data_valid(rd_vld),
        .ALU_OUT(alu_dat), .ALU_OUT_valid(alu_vld),
        .FIFO_IN(c_fifo), .Wr_Req(c_wr), .Busy(c_busy), .Drop(c_drop));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic strobe_rd(input logic [7:0] d);
        rd_dat = d;
        rd_vld = 1'b1;
    endtask

    task automatic strobe_alu(input logic [31:0] d);
        alu_dat = d;
        alu_vld = 1'b1;
    endtask

    task automatic clear_strobes();
        rd_vld  = 1'b0;
        alu_vld = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; full = 1'b0; rd_dat = '0; rd_vld = 1'b0; alu_dat = '0; alu_vld = 1'b0;
        #3;
        chk("rst_fifo", a_fifo, 8'h00);
        chk("rst_wr",   a_wr,   1'b0);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_drop", a_drop, 1'b0);
        step();
        rst_n = 1'b1;
        step();

        // single read word
        strobe_rd(8'hA5); step(); clear_strobes();
        chk("rd_word", a_fifo, 8'hA5);
        chk("rd_wr",   a_wr,   1'b1);
        chk("rd_busy", a_busy, 1'b1);
        step();
        chk("rd_idle_wr",   a_wr,   1'b0);
        chk("rd_idle_busy", a_busy, 1'b0);

        // ALU 16-bit, both word orders
        do_reset();
        strobe_alu(32'h0000_1234); step(); clear_strobes();
        chk("lsb_w0", a_fifo, 8'h34);
        chk("msb_w0", b_fifo, 8'h12);
        step();
        chk("lsb_w1", a_fifo, 8'h12);
        chk("msb_w1", b_fifo, 8'h34);
        chk("lsb_w1_wr", a_wr, 1'b1);
        step();
        chk("lsb_end_wr", a_wr, 1'b0);
        chk("msb_end_wr", b_wr, 1'b0);

        // 32-bit ALU with Full stall on word 2
        do_reset();
        strobe_alu(32'hDEAD_BEEF); step(); clear_strobes();
        chk("w32_w0", c_fifo, 8'hEF);
        step();
        chk("w32_w1", c_fifo, 8'hBE);
        full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("w32_hold", c_fifo, 8'hBE);
            chk("w32_hold_wr", c_wr, 1'b1);
        end
        full = 1'b0;
        step();
        chk("w32_w2", c_fifo, 8'hAD);
        step();
        chk("w32_w3", c_fifo, 8'hDE);
        step();
        chk("w32_end_wr", c_wr, 1'b0);

        // simultaneous strobes: read first, ALU from pending slot
        do_reset();
        strobe_rd(8'h55); strobe_alu(32'h0000_ABCD); step(); clear_strobes();
        chk("both_w0", a_fifo, 8'h55);
        chk("both_w0_drop", a_drop, 1'b0);
        chk("both_busy", a_busy, 1'b1);
        step();
        chk("both_w1", a_fifo, 8'hCD);
        chk("both_w1_wr", a_wr, 1'b1);
        chk("both_w1_drop", a_drop, 1'b0);
        step();
        chk("both_w2", a_fifo, 8'hAB);
        chk("both_w2_wr", a_wr, 1'b1);
        step();
        chk("both_end_wr", a_wr, 1'b0);
        chk("both_end_busy", a_busy, 1'b0);

        // Full held: pending fills, extra read dropped
        do_reset();
        full = 1'b1;
        strobe_rd(8'h11); step(); clear_strobes();
        chk("ff_w0", a_fifo, 8'h11);
        strobe_alu(32'h0000_0102); step(); clear_strobes();
        chk("ff_pend_hold", a_fifo, 8'h11);
        chk("ff_pend_drop", a_drop, 1'b0);
        strobe_rd(8'h77); step(); clear_strobes();
        chk("ff_drop", a_drop, 1'b1);
        chk("ff_drop_hold", a_fifo, 8'h11);
        step();
        chk("ff_drop_one", a_drop, 1'b0);
        full = 1'b0;
        step();
        chk("ff_p0", a_fifo, 8'h02);
        chk("ff_p0_wr", a_wr, 1'b1);
        step();
        chk("ff_p1", a_fifo, 8'h01);
        step();
        chk("ff_end_wr", a_wr, 1'b0);
        chk("ff_end_busy", a_busy, 1'b0);

        // strobe on the edge the slot drains takes the slot, no drop
        do_reset();
        strobe_rd(8'h01); strobe_alu(32'h0000_0A0B); step(); clear_strobes();
        chk("dr_w0", a_fifo, 8'h01);
        strobe_rd(8'h02); step(); clear_strobes();
        chk("dr_w1", a_fifo, 8'h0B);
        chk("dr_nodrop", a_drop, 1'b0);
        step();
        chk("dr_w2", a_fifo, 8'h0A);
        step();
        chk("dr_w3", a_fifo, 8'h02);
        chk("dr_w3_wr", a_wr, 1'b1);
        step();
        chk("dr_end_wr", a_wr, 1'b0);

        // strobe on last-word edge with empty slot starts at once
        do_reset();
        strobe_rd(8'h33); step(); clear_strobes();
        chk("bb_w0", a_fifo, 8'h33);
        strobe_alu(32'h0000_5566); step(); clear_strobes();
        chk("bb_w1", a_fifo, 8'h66);
        chk("bb_w1_wr", a_wr, 1'b1);
        step();
        chk("bb_w2", a_fifo, 8'h55);
        step();
        chk("bb_end_wr", a_wr, 1'b0);

        // asynchronous reset mid-frame
        do_reset();
        strobe_alu(32'h1122_3344); step(); clear_strobes();
        chk("ar_w0", c_fifo, 8'h44);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_fifo", c_fifo, 8'h00);
        chk("ar_wr",   c_wr,   1'b0);
        chk("ar_busy", c_busy, 1'b0);
        chk("ar_drop", c_drop, 1'b0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("ar_after_wr", c_wr, 1'b0);
            chk("ar_after_fifo", c_fifo, 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
